fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage directly upstream of the instruction decoder. It owns the 16-bit PC register and steers both instruction-memory read ports: a boot sequence drives them after reset, then they follow the decoder's requested addresses. It presents the fetched instruction word and its immediate word N to the decoder, and applies the decoder's cnt_en and pc_sload to the PC. It also detects STP and freezes the machine.

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the decoder-side and instruction-memory-side signals
//               of the fetch stage.
//               slave  : seen by fetch_unit (decoder/memory in, fetch out)
//               master : seen by the surrounding decoder/memory environment
//               Decoder side : cnt_en, pc_sload, new_pc, dec_addr1/2 (in),
//                              pc, instr, N, halted, running, instr_count (out)
//               Memory side  : instr_q1/2 (in), mem_addr1/2 (out)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        cnt_en;
    logic        pc_sload;
    logic [15:0] new_pc;
    logic [15:0] dec_addr1;
    logic [15:0] dec_addr2;
    logic [15:0] instr_q1;
    logic [15:0] instr_q2;
    logic [15:0] mem_addr1;
    logic [15:0] mem_addr2;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] N;
    logic        halted;
    logic        running;
    logic [15:0] instr_count;

    modport slave (
        input  cnt_en, pc_sload, new_pc, dec_addr1, dec_addr2, instr_q1, instr_q2,
        output mem_addr1, mem_addr2, pc, instr, N, halted, running, instr_count
    );

    modport master (
        output cnt_en, pc_sload, new_pc, dec_addr1, dec_addr2, instr_q1, instr_q2,
        input  mem_addr1, mem_addr2, pc, instr, N, halted, running, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC register and instruction-fetch stage. Boots from RESET_PC,
//               then forwards decoder-requested addresses to instruction
//               memory and memory data to the decoder. An STP word
//               (instr[15:11] == 5'b11111) freezes the stage until reset.
//               Ports: clk, reset (async, active high), bus (fetch_unit_if
//               slave: decoder controls/addresses, memory data, fetch outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_WORD    = 16'h0000,
    parameter int          BOOT_CYCLES = 1          // 1..4
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);

    localparam logic [1:0] c_ST_BOOT   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_HALT   = 2'd2;
    localparam logic [1:0] c_BOOT_LAST = 2'(BOOT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_boot_cnt;
    logic [15:0] r_pc;
    logic [15:0] r_instr_count;
    // Snapshot of the decoder-facing outputs taken on the STP cycle so HALT
    // shows a stable, X-free picture regardless of memory activity.
    logic [15:0] r_halt_instr;
    logic [15:0] r_halt_n;
    logic [15:0] r_halt_addr1;
    logic [15:0] r_halt_addr2;

    logic        w_stp;
    logic [15:0] w_mem_addr1;
    logic [15:0] w_mem_addr2;
    logic [15:0] w_instr;
    logic [15:0] w_n;

    assign w_stp = (bus.instr_q1[15:11] == 5'b11111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_BOOT;
            r_boot_cnt    <= 2'd0;
            r_pc          <= RESET_PC;
            r_instr_count <= 16'h0000;
            r_halt_instr  <= NOP_WORD;
            r_halt_n      <= 16'h0000;
            r_halt_addr1  <= RESET_PC;
            r_halt_addr2  <= RESET_PC + 16'd1;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    r_boot_cnt <= r_boot_cnt + 2'd1;
                    // The word at RESET_PC is on the memory port when RUN
                    // starts, so the PC already points past it.
                    if (r_boot_cnt == c_BOOT_LAST) begin
                        r_pc    <= RESET_PC + 16'd1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (bus.pc_sload) begin
                        r_pc <= bus.new_pc;
                    end else if (bus.cnt_en) begin
                        r_pc <= r_pc + 16'd1;
                    end
                    if (r_instr_count != 16'hFFFF) begin
                        r_instr_count <= r_instr_count + 16'd1;
                    end
                    if (w_stp) begin
                        r_state      <= c_ST_HALT;
                        r_halt_instr <= bus.instr_q1;
                        r_halt_n     <= bus.instr_q2;
                        r_halt_addr1 <= bus.dec_addr1;
                        r_halt_addr2 <= bus.dec_addr2;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_BOOT;
                end
            endcase
        end
    end

    always_comb begin
        w_mem_addr1 = RESET_PC;
        w_mem_addr2 = RESET_PC + 16'd1;
        w_instr     = NOP_WORD;
        w_n         = 16'h0000;
        case (r_state)
            c_ST_RUN: begin
                w_mem_addr1 = bus.dec_addr1;
                w_mem_addr2 = bus.dec_addr2;
                w_instr     = bus.instr_q1;
                w_n         = bus.instr_q2;
            end
            c_ST_HALT: begin
                w_mem_addr1 = r_halt_addr1;
                w_mem_addr2 = r_halt_addr2;
                w_instr     = r_halt_instr;
                w_n         = r_halt_n;
            end
            default: begin
                w_mem_addr1 = RESET_PC;
                w_mem_addr2 = RESET_PC + 16'd1;
                w_instr     = NOP_WORD;
                w_n         = 16'h0000;
            end
        endcase
    end

    assign bus.mem_addr1   = w_mem_addr1;
    assign bus.mem_addr2   = w_mem_addr2;
    assign bus.instr       = w_instr;
    assign bus.N           = w_n;
    assign bus.pc          = r_pc;
    assign bus.instr_count = r_instr_count;
    assign bus.running     = (r_state == c_ST_RUN);
    assign bus.halted      = (r_state == c_ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Instance A (BOOT_CYCLES=1)
//               runs against a one-cycle-latency memory model and a vector
//               table; instance B (BOOT_CYCLES=3) checks boot timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_unit_if ifa ();
    fetch_unit_if ifb ();

    fetch_unit #(.RESET_PC(16'h0000), .NOP_WORD(16'h0000), .BOOT_CYCLES(1)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa)
    );

    fetch_unit #(.RESET_PC(16'h0000), .NOP_WORD(16'h0000), .BOOT_CYCLES(3)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: words 0 and 1 are zero, everything else tags its address
    // with a 4'h1 top nibble so no stored word is an STP.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a < 16'd2) return 16'h0000;
        return {4'h1, a[11:0]};
    endfunction

    logic [15:0] mem_q1;
    logic [15:0] mem_q2;
    logic        ovr_en;
    logic [15:0] ovr_val;

    always @(posedge clk) begin
        mem_q1 <= mem_word(ifa.mem_addr1);
        mem_q2 <= mem_word(ifa.mem_addr2);
    end

    assign ifa.instr_q1 = ovr_en ? ovr_val : mem_q1;
    assign ifa.instr_q2 = mem_q2;

    assign ifb.cnt_en    = 1'b1;
    assign ifb.pc_sload  = 1'b0;
    assign ifb.new_pc    = 16'h0000;
    assign ifb.dec_addr1 = 16'h0010;
    assign ifb.dec_addr2 = 16'h0011;
    assign ifb.instr_q1  = 16'h1234;
    assign ifb.instr_q2  = 16'h5678;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] n;
    } sb_t;

    typedef struct {
        logic        cnt;
        logic        sl;
        logic [15:0] npc;
        logic [15:0] addr;
        logic [15:0] exp_pc;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[10];
    int          checks;
    int          failures;
    logic [15:0] exp_cnt;
    logic [15:0] exp_n;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checks--;
            chk({name, "_instr"}, ifa.instr, e.instr);
            chk({name, "_N"}, ifa.N, e.n);
        end
    endtask

    // Entered right after reset is released, at a falling edge.
    task automatic boot_seq();
        #1;
        chk("boot_running", {15'd0, ifa.running}, 16'd0);
        chk("boot_halted", {15'd0, ifa.halted}, 16'd0);
        chk("boot_addr1", ifa.mem_addr1, 16'h0000);
        chk("boot_addr2", ifa.mem_addr2, 16'h0001);
        chk("boot_instr", ifa.instr, 16'h0000);
        chk("boot_N", ifa.N, 16'h0000);
        chk("boot_b_instr", ifb.instr, 16'h0000);
        ovr_en = 1'b0;
        sb.push_back({mem_word(16'h0000), mem_word(16'h0001)});
        @(posedge clk); #1;
        exp_cnt = 16'd0;
        chk("boot1_running", {15'd0, ifa.running}, 16'd1);
        chk("boot1_pc", ifa.pc, 16'h0001);
        chk("boot1_count", ifa.instr_count, exp_cnt);
        sb_check("boot1");
        chk("boot1_b_running", {15'd0, ifb.running}, 16'd0);
        chk("boot1_b_N", ifb.N, 16'h0000);
        @(posedge clk); #1;
        exp_cnt++;
        chk("boot2_b_running", {15'd0, ifb.running}, 16'd0);
        @(posedge clk); #1;
        exp_cnt++;
        chk("boot3_b_running", {15'd0, ifb.running}, 16'd1);
        chk("boot3_b_pc", ifb.pc, 16'h0001);
        chk("boot3_pc", ifa.pc, 16'h0001);
        chk("boot3_count", ifa.instr_count, exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'h0002};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'h0002, 16'h0003};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 16'h0003, 16'h0004};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0005};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0005, 16'h0006};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0006};
        vecs[6] = '{1'b1, 1'b1, 16'h0040, 16'h0020, 16'h0040};
        vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 16'h0030, 16'hFFFF};
        vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0031, 16'h0000};
        vecs[9] = '{1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0001};

        rst           = 1'b0;
        ovr_en        = 1'b1;
        ovr_val       = 16'hABCD;
        ifa.cnt_en    = 1'b0;
        ifa.pc_sload  = 1'b0;
        ifa.new_pc    = 16'h0000;
        ifa.dec_addr1 = 16'h0000;
        ifa.dec_addr2 = 16'h0001;
        #1 rst = 1'b1;
        #1;
        chk("rst_pc", ifa.pc, 16'h0000);
        chk("rst_instr", ifa.instr, 16'h0000);
        chk("rst_N", ifa.N, 16'h0000);
        chk("rst_addr1", ifa.mem_addr1, 16'h0000);
        chk("rst_addr2", ifa.mem_addr2, 16'h0001);
        chk("rst_count", ifa.instr_count, 16'h0000);
        chk("rst_running", {15'd0, ifa.running}, 16'd0);
        chk("rst_halted", {15'd0, ifa.halted}, 16'd0);
        chk("rst_b_running", {15'd0, ifb.running}, 16'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        boot_seq();

        // Table-driven RUN traffic with scoreboarded fetch data.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifa.cnt_en    = vecs[i].cnt;
            ifa.pc_sload  = vecs[i].sl;
            ifa.new_pc    = vecs[i].npc;
            ifa.dec_addr1 = vecs[i].addr;
            ifa.dec_addr2 = vecs[i].addr + 16'd1;
            sb.push_back({mem_word(vecs[i].addr), mem_word(vecs[i].addr + 16'd1)});
            #1;
            chk($sformatf("vec%0d_addr1", i), ifa.mem_addr1, vecs[i].addr);
            chk($sformatf("vec%0d_addr2", i), ifa.mem_addr2, vecs[i].addr + 16'd1);
            @(posedge clk); #1;
            exp_cnt++;
            chk($sformatf("vec%0d_pc", i), ifa.pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_count", i), ifa.instr_count, exp_cnt);
            sb_check($sformatf("vec%0d", i));
        end

        // STP enters HALT; everything then stays frozen.
        @(negedge clk);
        ifa.cnt_en    = 1'b0;
        ifa.pc_sload  = 1'b0;
        ifa.dec_addr1 = 16'h0050;
        ifa.dec_addr2 = 16'h0051;
        ovr_en        = 1'b1;
        ovr_val       = 16'hF800;
        exp_n         = mem_word(16'h0041);
        #1;
        chk("stp_instr_run", ifa.instr, 16'hF800);
        chk("stp_N_run", ifa.N, exp_n);
        chk("stp_halted_run", {15'd0, ifa.halted}, 16'd0);
        @(posedge clk); #1;
        exp_cnt++;
        chk("halt_halted", {15'd0, ifa.halted}, 16'd1);
        chk("halt_running", {15'd0, ifa.running}, 16'd0);
        chk("halt_pc", ifa.pc, 16'h0001);
        chk("halt_count", ifa.instr_count, exp_cnt);
        chk("halt_addr1", ifa.mem_addr1, 16'h0050);
        chk("halt_addr2", ifa.mem_addr2, 16'h0051);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifa.cnt_en    = 1'b1;
            ifa.pc_sload  = 1'b1;
            ifa.new_pc    = 16'h1234;
            ovr_val       = 16'($urandom);
            ifa.dec_addr1 = 16'($urandom);
            ifa.dec_addr2 = 16'($urandom);
            @(posedge clk); #1;
            chk($sformatf("frz%0d_pc", i), ifa.pc, 16'h0001);
            chk($sformatf("frz%0d_instr", i), ifa.instr, 16'hF800);
            chk($sformatf("frz%0d_N", i), ifa.N, exp_n);
            chk($sformatf("frz%0d_count", i), ifa.instr_count, exp_cnt);
            chk($sformatf("frz%0d_addr1", i), ifa.mem_addr1, 16'h0050);
            chk($sformatf("frz%0d_halted", i), {15'd0, ifa.halted}, 16'd1);
        end

        // Leave HALT by reset, run to pc=0x0023, then reset between edges.
        @(negedge clk);
        ifa.cnt_en   = 1'b0;
        ifa.pc_sload = 1'b0;
        ifa.dec_addr1 = 16'h0000;
        ifa.dec_addr2 = 16'h0001;
        ovr_val      = 16'hABCD;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        boot_seq();
        @(negedge clk);
        ifa.pc_sload = 1'b1;
        ifa.new_pc   = 16'h0023;
        @(posedge clk); #1;
        exp_cnt++;
        chk("mid_pc_loaded", ifa.pc, 16'h0023);
        #2;
        ovr_en  = 1'b1;
        ovr_val = 16'hABCD;
        rst     = 1'b1;
        #1;
        chk("async_pc", ifa.pc, 16'h0000);
        chk("async_instr", ifa.instr, 16'h0000);
        chk("async_N", ifa.N, 16'h0000);
        chk("async_running", {15'd0, ifa.running}, 16'd0);
        chk("async_count", ifa.instr_count, 16'h0000);
        chk("async_addr1", ifa.mem_addr1, 16'h0000);
        chk("async_b_running", {15'd0, ifb.running}, 16'd0);
        @(negedge clk);
        ifa.pc_sload = 1'b0;
        rst = 1'b0;
        boot_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
